// File: rtl/cpu_machine_ctrl.sv
// cpu_machine_ctrl: 8-phase fetch/execute sequencer for the 8-bit CPU.
// Decodes the IR opcode into registered datapath strobes; samples the ALU zero flag for SKZ.
`default_nettype none

module cpu_machine_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       rd,
  output logic       wr,
  output logic       load_ir,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_acc,
  output logic       alu_ena,
  output logic       datactl_ena,
  output logic       halt
);

  localparam logic [2:0] HLT = 3'b000;
  localparam logic [2:0] SKZ = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] AND = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] LDA = 3'b101;
  localparam logic [2:0] STA = 3'b110;
  localparam logic [2:0] JMP = 3'b111;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    S0     = 4'd1,
    S1     = 4'd2,
    S2     = 4'd3,
    S3     = 4'd4,
    S4     = 4'd5,
    S5     = 4'd6,
    S6     = 4'd7,
    S7     = 4'd8,
    HALTED = 4'd9
  } state_t;

  state_t state_q, state_d;
  logic   skz_zero_q, skz_zero_d;
  logic   rd_q, wr_q, load_ir_q, inc_pc_q, load_pc_q, load_acc_q, alu_ena_q, datactl_ena_q, halt_q;
  logic   rd_d, wr_d, load_ir_d, inc_pc_d, load_pc_d, load_acc_d, alu_ena_d, datactl_ena_d, halt_d;
  logic   is_alu_op;

  assign is_alu_op = (opcode == ADD) || (opcode == AND) || (opcode == XOR) || (opcode == LDA);

  always_comb begin
    state_d    = IDLE;
    skz_zero_d = skz_zero_q;
    case (state_q)
      IDLE:    state_d = ena ? S0 : IDLE;
      S0:      state_d = S1;
      S1:      state_d = S2;
      S2:      state_d = S3;
      S3:      state_d = (opcode == HLT) ? HALTED : S4;
      S4: begin
        state_d    = S5;
        skz_zero_d = zero;
      end
      S5:      state_d = S6;
      S6:      state_d = S7;
      S7:      state_d = ena ? S0 : IDLE;
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered so they are registered
  // alongside it and hold for that state's whole cycle.
  always_comb begin
    rd_d          = 1'b0;
    wr_d          = 1'b0;
    load_ir_d     = 1'b0;
    inc_pc_d      = 1'b0;
    load_pc_d     = 1'b0;
    load_acc_d    = 1'b0;
    alu_ena_d     = 1'b0;
    datactl_ena_d = 1'b0;
    halt_d        = 1'b0;
    case (state_d)
      S0: begin
        rd_d      = 1'b1;
        load_ir_d = 1'b1;
      end
      S1: begin
        rd_d      = 1'b1;
        load_ir_d = 1'b1;
        inc_pc_d  = 1'b1;
      end
      S3: inc_pc_d = (opcode != HLT);
      S4: begin
        rd_d          = is_alu_op;
        alu_ena_d     = is_alu_op;
        datactl_ena_d = (opcode == STA);
        load_pc_d     = (opcode == JMP);
      end
      S5: begin
        rd_d          = is_alu_op;
        load_acc_d    = is_alu_op;
        datactl_ena_d = (opcode == STA);
        wr_d          = (opcode == STA);
        load_pc_d     = (opcode == JMP);
        inc_pc_d      = (opcode == SKZ) && zero;
      end
      S6: begin
        rd_d          = is_alu_op;
        datactl_ena_d = (opcode == STA);
      end
      S7:      inc_pc_d = (opcode == SKZ) && skz_zero_q;
      HALTED:  halt_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      skz_zero_q    <= 1'b0;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      load_ir_q     <= 1'b0;
      inc_pc_q      <= 1'b0;
      load_pc_q     <= 1'b0;
      load_acc_q    <= 1'b0;
      alu_ena_q     <= 1'b0;
      datactl_ena_q <= 1'b0;
      halt_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      skz_zero_q    <= skz_zero_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      load_ir_q     <= load_ir_d;
      inc_pc_q      <= inc_pc_d;
      load_pc_q     <= load_pc_d;
      load_acc_q    <= load_acc_d;
      alu_ena_q     <= alu_ena_d;
      datactl_ena_q <= datactl_ena_d;
      halt_q        <= halt_d;
    end
  end

  assign rd          = rd_q;
  assign wr          = wr_q;
  assign load_ir     = load_ir_q;
  assign inc_pc      = inc_pc_q;
  assign load_pc     = load_pc_q;
  assign load_acc    = load_acc_q;
  assign alu_ena     = alu_ena_q;
  assign datactl_ena = datactl_ena_q;
  assign halt        = halt_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_machine_ctrl.sv
// tb_cpu_machine_ctrl: directed and randomized checks of the sequencer against a phase-table model.
`default_nettype none

module tb_cpu_machine_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic       zero = 1'b0;
  logic       rd, wr, load_ir, inc_pc, load_pc, load_acc, alu_ena, datactl_ena, halt;

  int errors = 0;
  int checks = 0;

  // Model position: -1 idle, 0..7 phases, 8 halted
  int m_state = -1;

  cpu_machine_ctrl dut (
    .clk(clk), .rst(rst), .ena(ena), .opcode(opcode), .zero(zero),
    .rd(rd), .wr(wr), .load_ir(load_ir), .inc_pc(inc_pc), .load_pc(load_pc),
    .load_acc(load_acc), .alu_ena(alu_ena), .datactl_ena(datactl_ena), .halt(halt)
  );

  always #5 clk = ~clk;

  // Bit order: rd wr load_ir inc_pc load_pc load_acc alu_ena datactl_ena halt
  function automatic logic [8:0] expected(int ph, logic [2:0] op, logic z);
    logic alu_op;
    logic [8:0] v;
    alu_op = (op == 3'b010) || (op == 3'b011) || (op == 3'b100) || (op == 3'b101);
    v = 9'b0;
    case (ph)
      0: v = 9'b101000000;
      1: v = 9'b101100000;
      3: v = (op != 3'b000) ? 9'b000100000 : 9'b0;
      4: if (alu_op) v = 9'b100000100;
         else if (op == 3'b110) v = 9'b000000010;
         else if (op == 3'b111) v = 9'b000010000;
      5: if (alu_op) v = 9'b100001000;
         else if (op == 3'b110) v = 9'b010000010;
         else if (op == 3'b111) v = 9'b000010000;
         else if (op == 3'b001 && z) v = 9'b000100000;
      6: if (alu_op) v = 9'b100000000;
         else if (op == 3'b110) v = 9'b000000010;
      7: if (op == 3'b001 && z) v = 9'b000100000;
      8: v = 9'b000000001;
      default: v = 9'b0;
    endcase
    return v;
  endfunction

  function automatic int next_state(int s, logic e, logic [2:0] op);
    if (s == 8) return 8;
    if (s == -1 || s == 7) return e ? 0 : -1;
    if (s == 3 && op == 3'b000) return 8;
    return s + 1;
  endfunction

  task automatic check_outputs(string tag);
    logic [8:0] got, exp;
    got = {rd, wr, load_ir, inc_pc, load_pc, load_acc, alu_ena, datactl_ena, halt};
    exp = (m_state < 0) ? 9'b0 : expected(m_state, opcode, zero);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s phase=%0d op=%0d zero=%0b: observed %b expected %b",
             tag, m_state, opcode, zero, got, exp);
    end
    checks++;
    assert ({(rd & wr), (load_pc & load_acc)} === 2'b00) else begin
      errors++;
      $error("FAIL %s_invariant: observed rd&wr,load_pc&load_acc=%b%b expected 00",
             tag, rd & wr, load_pc & load_acc);
    end
  endtask

  task automatic step(string tag);
    @(posedge clk);
    m_state = next_state(m_state, ena, opcode);
    #1;
    check_outputs(tag);
  endtask

  task automatic run_instr(logic [2:0] op, logic z, string tag);
    opcode = op;
    zero   = z;
    ena    = 1'b1;
    for (int i = 0; i < 8; i++) step(tag);
  endtask

  initial begin
    // Reset state
    #12;
    m_state = -1;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step("idle_after_reset");

    // Reset asserted during S4 of ADD
    opcode = 3'b010; zero = 1'b0; ena = 1'b1;
    for (int i = 0; i < 5; i++) step("add_pre_reset");
    #2 rst = 1'b1;
    #1 m_state = -1;
    check_outputs("reset_in_s4");
    ena = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step("idle_ena0");

    // Directed instructions back to back
    run_instr(3'b010, 1'b0, "add");
    run_instr(3'b110, 1'b0, "sta");
    run_instr(3'b001, 1'b1, "skz_z1");
    run_instr(3'b001, 1'b0, "skz_z0");
    run_instr(3'b111, 1'b0, "jmp");
    run_instr(3'b011, 1'b1, "and");
    run_instr(3'b100, 1'b0, "xor");
    run_instr(3'b101, 1'b1, "lda");

    // ena dropping mid-instruction has no effect
    opcode = 3'b010; zero = 1'b0; ena = 1'b1;
    step("ena_drop");
    ena = 1'b0;
    for (int i = 0; i < 9; i++) step("ena_drop");

    // Randomized instruction stream; ena toggles freely every cycle
    for (int i = 0; i < 600; i++) begin
      if (m_state == -1 || m_state == 7) begin
        opcode = 3'($urandom_range(1, 7));
        zero   = 1'($urandom_range(0, 1));
      end
      ena = ($urandom_range(0, 3) != 0);
      step("random");
    end

    // Halt, then ena toggling must not wake it
    for (int i = 0; i < 12 && m_state != 7; i++) step("drain");
    opcode = 3'b000; zero = 1'b0; ena = 1'b1;
    for (int i = 0; i < 6; i++) step("hlt");
    for (int i = 0; i < 20; i++) begin
      ena = ~ena;
      step("halted_ena_toggle");
    end
    rst = 1'b1;
    #1 m_state = -1;
    check_outputs("reset_from_halt");
    ena = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) step("idle_after_halt");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
